serial_subtractor: RTL and testbench

//  Bit-serial two's-complement subtractor: D = A - B, one bit per clock, LSB first,

---
 rtl/serial_subtractor_pkg.sv | 11 +
 rtl/serial_subtractor_if.sv | 25 ++
 rtl/serial_subtractor_fa_bit_cell.sv | 13 +
 rtl/serial_subtractor.sv | 98 +++++++++
 tb/tb_serial_subtractor.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and default width.
package serial_subtractor_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/done handshake plus operand and result bus of the serial subtractor.
interface serial_subtractor_if #(
  parameter int WIDTH = serial_subtractor_pkg::DEFAULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] d;
  logic             borrow;
  logic             ovf;

  modport master (
    output start, a, b,
    input  busy, done, d, borrow, ovf
  );

  modport slave (
    input  start, a, b,
    output busy, done, d, borrow, ovf
  );

endinterface

// File: rtl/serial_subtractor_fa_bit_cell.sv
// One-bit combinational full adder; the serial datapath reuses it every cycle.
module fa_bit_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic s_o,
  output logic cout_o
);

  assign s_o    = a_i ^ b_i ^ cin_i;
  assign cout_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor D = A + ~B + 1, LSB first, one bit per clock.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  serial_subtractor_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_PREV = CW'(WIDTH - 2);

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic             carry_q;
  logic             cmsb_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] d_q;
  logic             borrow_q;
  logic             ovf_q;

  logic             sum_d;
  logic             carry_d;

  // Subtraction as addition: the cell sees the inverted subtrahend bit.
  fa_bit_cell u_fa (
    .a_i    (a_q[0]),
    .b_i    (~b_q[0]),
    .cin_i  (carry_q),
    .s_o    (sum_d),
    .cout_o (carry_d)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      carry_q  <= 1'b0;
      cmsb_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      d_q      <= '0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            carry_q <= 1'b1;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          res_q   <= {sum_d, res_q[WIDTH-1:1]};
          carry_q <= carry_d;
          cnt_q   <= cnt_q + CW'(1);
          // Carry out of bit WIDTH-2 is the carry into the MSB.
          if (cnt_q == CNT_PREV) begin
            cmsb_q <= carry_d;
          end
          if (cnt_q == CNT_LAST) begin
            d_q      <= {sum_d, res_q[WIDTH-1:1]};
            borrow_q <= ~carry_d;
            ovf_q    <= cmsb_q ^ carry_d;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.d      = d_q;
  assign bus.borrow = borrow_q;
  assign bus.ovf    = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: vector table plus handshake/reset corner sequences.
module tb_serial_subtractor;

  localparam int W = 8;

  logic clk;
  logic rst_n;

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] d;
    logic         borrow;
    logic         ovf;
  } vec_t;

  vec_t vecs[9];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Pulses START for one cycle, then counts edges until DONE (-1 on timeout).
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, output int lat);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        lat = k;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    int k_done;
    bit seen_done;

    vecs[0] = '{8'd200, 8'd55,  8'd145, 1'b0, 1'b0};
    vecs[1] = '{8'd10,  8'd20,  8'hF6,  1'b1, 1'b0};
    vecs[2] = '{8'd0,   8'd0,   8'd0,   1'b0, 1'b0};
    vecs[3] = '{8'h80,  8'h01,  8'h7F,  1'b0, 1'b1};
    vecs[4] = '{8'h7F,  8'hFF,  8'h80,  1'b1, 1'b1};
    vecs[5] = '{8'hFF,  8'h01,  8'hFE,  1'b0, 1'b0};
    vecs[6] = '{8'h00,  8'h01,  8'hFF,  1'b1, 1'b0};
    vecs[7] = '{8'h80,  8'h7F,  8'h01,  1'b0, 1'b1};
    vecs[8] = '{8'h55,  8'hAA,  8'hAB,  1'b1, 1'b1};

    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    rst_n     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy",   32'(bus.busy),   32'd0);
    chk("reset_done",   32'(bus.done),   32'd0);
    chk("reset_d",      32'(bus.d),      32'd0);
    chk("reset_borrow", 32'(bus.borrow), 32'd0);
    chk("reset_ovf",    32'(bus.ovf),    32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      do_op(vecs[i].a, vecs[i].b, lat);
      $display("op %0d: A=%0d B=%0d -> D=%0d BORROW=%0b OVF=%0b latency=%0d",
               i, vecs[i].a, vecs[i].b, bus.d, bus.borrow, bus.ovf, lat);
      chk($sformatf("vec%0d_latency", i), 32'(lat),        32'd8);
      chk($sformatf("vec%0d_d", i),       32'(bus.d),      32'(vecs[i].d));
      chk($sformatf("vec%0d_borrow", i),  32'(bus.borrow), 32'(vecs[i].borrow));
      chk($sformatf("vec%0d_ovf", i),     32'(bus.ovf),    32'(vecs[i].ovf));
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_done_pulse", i), 32'(bus.done), 32'd0);
    end

    // START while busy must be ignored; BUSY stays high for cycles 1..8.
    @(negedge clk);
    bus.start = 1'b1; bus.a = 8'd100; bus.b = 8'd1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    k_done = -1;
    for (int k = 1; k <= 20; k++) begin
      if (k == 3) begin
        bus.start = 1'b1; bus.a = 8'd5; bus.b = 8'd5;
      end else begin
        bus.start = 1'b0; bus.a = '0; bus.b = '0;
      end
      @(posedge clk);
      #1;
      if (k <= 7) chk($sformatf("ignore_busy_c%0d", k), 32'(bus.busy), 32'd1);
      if (bus.done) begin
        k_done = k;
        break;
      end
    end
    bus.start = 1'b0;
    $display("ignore-start op: A=100 B=1 -> D=%0d done_cycle=%0d", bus.d, k_done);
    chk("ignore_latency", 32'(k_done), 32'd8);
    chk("ignore_d",       32'(bus.d),  32'd99);
    chk("ignore_borrow",  32'(bus.borrow), 32'd0);

    // Back-to-back: START held in the DONE cycle starts the next op at once.
    do_op(8'd20, 8'd3, lat);
    chk("b2b_first_latency", 32'(lat),   32'd8);
    chk("b2b_first_d",       32'(bus.d), 32'd17);
    bus.start = 1'b1; bus.a = 8'd9; bus.b = 8'd4;
    k_done = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      bus.start = 1'b0; bus.a = '0; bus.b = '0;
      if (k == 1) chk("b2b_busy_after_accept", 32'(bus.busy), 32'd1);
      if (bus.done) begin
        k_done = k;
        break;
      end
    end
    $display("back-to-back op: A=9 B=4 -> D=%0d gap=%0d", bus.d, k_done);
    chk("b2b_gap", 32'(k_done), 32'd9);
    chk("b2b_d",   32'(bus.d),  32'd5);

    // Asynchronous reset after three bits aborts the operation.
    @(negedge clk);
    bus.start = 1'b1; bus.a = 8'd200; bus.b = 8'd55;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy",   32'(bus.busy),   32'd0);
    chk("arst_d",      32'(bus.d),      32'd0);
    chk("arst_borrow", 32'(bus.borrow), 32'd0);
    chk("arst_ovf",    32'(bus.ovf),    32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen_done = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      if (bus.done) seen_done = 1'b1;
    end
    $display("reset-abort: done_seen=%0b", seen_done);
    chk("arst_no_done", 32'(seen_done), 32'd0);

    do_op(8'd3, 8'd7, lat);
    $display("post-reset op: A=3 B=7 -> D=%0d BORROW=%0b latency=%0d", bus.d, bus.borrow, lat);
    chk("post_rst_latency", 32'(lat),        32'd8);
    chk("post_rst_d",       32'(bus.d),      32'd252);
    chk("post_rst_borrow",  32'(bus.borrow), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
